alu_rr_scheduler: RTL

//  Round-robin scheduler sharing one 5-bit, 8-op ALU (add/sub/and/or/xor/not/shl/shr)

---
 rtl/alu_pkg.sv | 34 +++
 rtl/alu5_core.sv | 34 +++
 rtl/alu_rr_scheduler.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared types and constants for the 5-bit ALU and its round-robin scheduler.
package alu_pkg;

  localparam int unsigned ALU_W = 5;
  localparam int unsigned OP_W  = 3;

  localparam logic [OP_W-1:0] OP_ADD = 3'd0;
  localparam logic [OP_W-1:0] OP_SUB = 3'd1;
  localparam logic [OP_W-1:0] OP_AND = 3'd2;
  localparam logic [OP_W-1:0] OP_OR  = 3'd3;
  localparam logic [OP_W-1:0] OP_XOR = 3'd4;
  localparam logic [OP_W-1:0] OP_NOT = 3'd5;
  localparam logic [OP_W-1:0] OP_SHL = 3'd6;
  localparam logic [OP_W-1:0] OP_SHR = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } sched_state_e;

  typedef struct packed {
    logic [OP_W-1:0]  op;
    logic [ALU_W-1:0] a;
    logic [ALU_W-1:0] b;
  } alu_req_t;

  typedef struct packed {
    logic [ALU_W-1:0] result;
    logic             carry;
    logic             zero;
  } alu_rsp_t;

endpackage

// File: rtl/alu5_core.sv
// Combinational 5-bit, 8-operation ALU; carry is only produced by add.
module alu5_core
  import alu_pkg::*;
(
  input  alu_req_t req_i,
  output alu_rsp_t rsp_o
);

  logic [ALU_W:0]   sum_c;
  logic [ALU_W-1:0] result_c;
  logic             carry_c;

  always_comb begin
    sum_c    = {1'b0, req_i.a} + {1'b0, req_i.b};
    result_c = '0;
    carry_c  = 1'b0;
    case (req_i.op)
      OP_ADD: {carry_c, result_c} = sum_c;
      OP_SUB: result_c = req_i.a - req_i.b;
      OP_AND: result_c = req_i.a & req_i.b;
      OP_OR:  result_c = req_i.a | req_i.b;
      OP_XOR: result_c = req_i.a ^ req_i.b;
      OP_NOT: result_c = ~req_i.a;
      OP_SHL: result_c = {req_i.a[ALU_W-2:0], 1'b0};
      OP_SHR: result_c = {1'b0, req_i.a[ALU_W-1:1]};
      default: result_c = '0;
    endcase
  end

  assign rsp_o.result = result_c;
  assign rsp_o.carry  = carry_c;
  assign rsp_o.zero   = (result_c == '0);

endmodule

// File: rtl/alu_rr_scheduler.sv
// Round-robin scheduler sharing one alu5_core among NREQ requesters (IDLE->EXEC->RESP).
// Define ALU_RR_SCHED_STATS_EN to build the saturating per-requester grant counters.
module alu_rr_scheduler
  import alu_pkg::*;
#(
  parameter  int unsigned NREQ = 2,
  localparam int unsigned IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [OP_W*NREQ-1:0]  req_op,
  input  logic [ALU_W*NREQ-1:0] req_a,
  input  logic [ALU_W*NREQ-1:0] req_b,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [IDW-1:0]        resp_id,
  output logic [ALU_W-1:0]      resp_result,
  output logic                  resp_carry,
  output logic                  resp_zero,
  output logic                  busy,
  output logic [8*NREQ-1:0]     stat_grants
);

  sched_state_e   state_q;
  logic [IDW-1:0] last_q;
  logic [IDW-1:0] id_q;
  alu_req_t       req_q;
  alu_rsp_t       rsp_q;
  logic [IDW-1:0] resp_id_q;
  logic           resp_valid_q;
  logic           busy_q;

  logic           found_c;
  logic [IDW-1:0] winner_c;
  logic           grant_c;
  alu_req_t       sel_c;
  alu_rsp_t       alu_rsp_c;

  // First valid requester after the last winner, wrapping modulo NREQ.
  always_comb begin
    found_c  = 1'b0;
    winner_c = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      if (!found_c && req_valid[(32'(last_q) + k) % NREQ]) begin
        found_c  = 1'b1;
        winner_c = IDW'((32'(last_q) + k) % NREQ);
      end
    end
  end

  assign grant_c = (state_q == ST_IDLE) && found_c;

  always_comb begin
    req_ready = '0;
    if (grant_c) req_ready[winner_c] = 1'b1;
  end

  always_comb begin
    sel_c.op = req_op[OP_W*32'(winner_c) +: OP_W];
    sel_c.a  = req_a[ALU_W*32'(winner_c) +: ALU_W];
    sel_c.b  = req_b[ALU_W*32'(winner_c) +: ALU_W];
  end

  alu5_core u_core (
    .req_i (req_q),
    .rsp_o (alu_rsp_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      last_q       <= IDW'(NREQ - 1);
      id_q         <= '0;
      req_q        <= '0;
      rsp_q        <= '0;
      resp_id_q    <= '0;
      resp_valid_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (grant_c) begin
            req_q   <= sel_c;
            id_q    <= winner_c;
            last_q  <= winner_c;
            busy_q  <= 1'b1;
            state_q <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          rsp_q        <= alu_rsp_c;
          resp_id_q    <= id_q;
          resp_valid_q <= 1'b1;
          state_q      <= ST_RESP;
        end
        ST_RESP: begin
          if (resp_ready) begin
            resp_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            state_q      <= ST_IDLE;
          end
        end
        default: begin
          resp_valid_q <= 1'b0;
          busy_q       <= 1'b0;
          state_q      <= ST_IDLE;
        end
      endcase
    end
  end

  assign resp_valid  = resp_valid_q;
  assign resp_id     = resp_id_q;
  assign resp_result = rsp_q.result;
  assign resp_carry  = rsp_q.carry;
  assign resp_zero   = rsp_q.zero;
  assign busy        = busy_q;

`ifdef ALU_RR_SCHED_STATS_EN
  logic [7:0] grants_q [NREQ];

  // Saturating grant counters, one per requester.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREQ; i++) grants_q[i] <= '0;
    end else if (grant_c && (grants_q[winner_c] != 8'hFF)) begin
      grants_q[winner_c] <= grants_q[winner_c] + 8'd1;
    end
  end

  always_comb begin
    stat_grants = '0;
    for (int unsigned i = 0; i < NREQ; i++) stat_grants[8*i +: 8] = grants_q[i];
  end
`else
  assign stat_grants = '0;
`endif

endmodule
